nwc_bram_dma: RTL and testbench

Parametrised memory-side sequencer for the negacyclic-convolution datapath. It streams the two input polynomials out of dual-half (up/down) BRAMs into the butterfly core over a valid/ready handshake, and tolerates any BRAM read latency and core backpressure. It writes the core's result pairs back through a byte-enabled BRAM port and reports start/completion status. It generalises the fixed N=4096, 32-bit, single-latency I/O path of `nwc_top` to arbitrary length, width, read latency and address mode.

---
 rtl/nwc_bram_dma_if.sv | 48 ++++
 rtl/nwc_bram_dma.sv | 175 +++++++++++++++++
 tb/tb_nwc_bram_dma.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/nwc_bram_dma_if.sv
// Bus bundle for nwc_bram_dma: start/status, input BRAM read port, load stream,
// result stream and output BRAM write port. master = sequencer side.
interface nwc_bram_dma_if #(
  parameter int W  = 32,
  parameter int IW = 11,
  parameter int AW = 13
);
  logic            start;
  logic            start_ready;
  logic [AW-1:0]   addrr;
  logic [W-1:0]    data_in0_up;
  logic [W-1:0]    data_in0_down;
  logic [W-1:0]    data_in1_up;
  logic [W-1:0]    data_in1_down;
  logic            ld_valid;
  logic            ld_ready;
  logic [W-1:0]    ld_a_up;
  logic [W-1:0]    ld_a_down;
  logic [W-1:0]    ld_b_up;
  logic [W-1:0]    ld_b_down;
  logic [IW-1:0]   ld_idx;
  logic            st_valid;
  logic            st_ready;
  logic [W-1:0]    st_up;
  logic [W-1:0]    st_down;
  logic [AW-1:0]   addrw;
  logic [W-1:0]    data_out_up;
  logic [W-1:0]    data_out_down;
  logic [W/8-1:0]  out_wen;
  logic            memory_writable;
  logic            output_ready;

  modport master (
    input  start, data_in0_up, data_in0_down, data_in1_up, data_in1_down,
           ld_ready, st_valid, st_up, st_down,
    output start_ready, addrr, ld_valid, ld_a_up, ld_a_down, ld_b_up, ld_b_down,
           ld_idx, st_ready, addrw, data_out_up, data_out_down, out_wen,
           memory_writable, output_ready
  );

  modport slave (
    output start, data_in0_up, data_in0_down, data_in1_up, data_in1_down,
           ld_ready, st_valid, st_up, st_down,
    input  start_ready, addrr, ld_valid, ld_a_up, ld_a_down, ld_b_up, ld_b_down,
           ld_idx, st_ready, addrw, data_out_up, data_out_down, out_wen,
           memory_writable, output_ready
  );
endinterface

// File: rtl/nwc_bram_dma.sv
// Memory-side sequencer: streams polynomial pairs from dual-half BRAMs into the
// butterfly core through a credit-limited FIFO and writes results back.
module nwc_bram_dma #(
  parameter int N         = 4096,
  parameter int W         = 32,
  parameter int RD_LAT    = 1,
  parameter int BYTE_ADDR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  nwc_bram_dma_if.master    bus
);
  localparam int IW    = $clog2(N/2);
  localparam int SH    = (BYTE_ADDR != 0) ? $clog2(W/8) : 0;
  localparam int AW    = IW + SH;
  localparam int BE    = W/8;
  localparam int DEPTH = RD_LAT + 2;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int PW    = $clog2(DEPTH);
  localparam logic [IW:0] HALF = (IW+1)'(N/2);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  typedef struct packed {
    logic [W-1:0]  a_up;
    logic [W-1:0]  a_down;
    logic [W-1:0]  b_up;
    logic [W-1:0]  b_down;
    logic [IW-1:0] idx;
  } ld_ent_t;

  state_t state, state_nx;

  logic [IW:0]   i, d, j, i_inc;
  logic [AW-1:0] addrr_q, addrw_q;
  logic [W-1:0]  dout_up_q, dout_dn_q;
  logic [BE-1:0] wen_q;

  // read-issue tracking: one bit per outstanding BRAM read, with its index
  logic [RD_LAT-1:0]         vld_pipe;
  logic [RD_LAT-1:0][IW-1:0] idx_pipe;

  ld_ent_t       fifo [DEPTH];
  ld_ent_t       head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] occ, infl;

  logic start_go, issue, push, pop, st_acc;
  logic start_ready_c, mw_c, out_rdy_c, st_ready_c;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = LOAD;
      LOAD: if (d == HALF) state_nx = (j == HALF) ? DONE : WAIT;
      WAIT: if (j == HALF) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    start_ready_c = (state == IDLE);
    mw_c          = (state != LOAD);
    out_rdy_c     = (state == DONE);
    st_ready_c    = ((state == LOAD) || (state == WAIT)) && (j < HALF);
  end

  // ---------------- control ----------------
  always_comb begin
    infl = '0;
    for (int k = 0; k < RD_LAT; k++) infl = infl + CW'(vld_pipe[k]);
  end

  assign i_inc    = i + 1'b1;
  assign start_go = (state == IDLE) && bus.start;
  // credit check keeps queued + outstanding reads within FIFO capacity
  assign issue    = (state == LOAD) && (i < HALF) && ((occ + infl) < CW'(DEPTH));
  assign push     = vld_pipe[RD_LAT-1];
  assign pop      = (occ != '0) && bus.ld_ready;
  assign st_acc   = bus.st_valid && st_ready_c;

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i         <= '0;
      d         <= '0;
      j         <= '0;
      addrr_q   <= '0;
      addrw_q   <= '0;
      dout_up_q <= '0;
      dout_dn_q <= '0;
      wen_q     <= '0;
      vld_pipe  <= '0;
      idx_pipe  <= '0;
    end else begin
      if (start_go) begin
        i       <= '0;
        d       <= '0;
        j       <= '0;
        addrr_q <= '0;
      end else begin
        if (issue) begin
          i       <= i_inc;
          addrr_q <= AW'(i_inc) << SH;
        end
        if (pop)    d <= d + 1'b1;
        if (st_acc) j <= j + 1'b1;
      end
      wen_q <= {BE{st_acc}};
      if (st_acc) begin
        addrw_q   <= AW'(j) << SH;
        dout_up_q <= bus.st_up;
        dout_dn_q <= bus.st_down;
      end
      vld_pipe[0] <= issue;
      idx_pipe[0] <= i[IW-1:0];
      for (int k = 1; k < RD_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        idx_pipe[k] <= idx_pipe[k-1];
      end
    end
  end

  // ---------------- load FIFO ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int k = 0; k < DEPTH; k++) fifo[k] <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= '{a_up:   bus.data_in0_up,
                          a_down: bus.data_in0_down,
                          b_up:   bus.data_in1_up,
                          b_down: bus.data_in1_down,
                          idx:    idx_pipe[RD_LAT-1]};
        wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign head = fifo[rd_ptr];

  // ---------------- outputs ----------------
  assign bus.start_ready     = start_ready_c;
  assign bus.memory_writable = mw_c;
  assign bus.output_ready    = out_rdy_c;
  assign bus.st_ready        = st_ready_c;
  assign bus.addrr           = addrr_q;
  assign bus.ld_valid        = (occ != '0);
  assign bus.ld_a_up         = head.a_up;
  assign bus.ld_a_down       = head.a_down;
  assign bus.ld_b_up         = head.b_up;
  assign bus.ld_b_down       = head.b_down;
  assign bus.ld_idx          = head.idx;
  assign bus.addrw           = addrw_q;
  assign bus.data_out_up     = dout_up_q;
  assign bus.data_out_down   = dout_dn_q;
  assign bus.out_wen         = wen_q;

endmodule

// File: tb/tb_nwc_bram_dma.sv
// Directed bench for nwc_bram_dma: byte-address/RD_LAT=1/W=32 instance and
// word-address/RD_LAT=3/W=64 instance, each with a behavioural BRAM.
module tb_nwc_bram_dma;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nwc_bram_dma_if #(.W(32), .IW(3), .AW(5)) b0 ();
  nwc_bram_dma_if #(.W(64), .IW(3), .AW(3)) b1 ();

  nwc_bram_dma #(.N(16), .W(32), .RD_LAT(1), .BYTE_ADDR(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  nwc_bram_dma #(.N(16), .W(64), .RD_LAT(3), .BYTE_ADDR(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  // BRAM models: registered address pipeline of depth RD_LAT
  logic [4:0] a0_q;
  logic [2:0] a1_q [3];
  always @(posedge clk) begin
    a0_q    <= b0.addrr;
    a1_q[0] <= b1.addrr;
    a1_q[1] <= a1_q[0];
    a1_q[2] <= a1_q[1];
  end
  assign b0.data_in0_up   = 32'(a0_q >> 2);
  assign b0.data_in0_down = 32'(a0_q >> 2) + 32'd8;
  assign b0.data_in1_up   = 32'(a0_q >> 2) + 32'd16;
  assign b0.data_in1_down = 32'(a0_q >> 2) + 32'd24;
  assign b1.data_in0_up   = 64'(a1_q[2]);
  assign b1.data_in0_down = 64'(a1_q[2]) + 64'd8;
  assign b1.data_in1_up   = 64'(a1_q[2]) + 64'd16;
  assign b1.data_in1_down = 64'(a1_q[2]) + 64'd24;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_rst0();
    chk("rst_start_ready", 64'(b0.start_ready), 64'd1);
    chk("rst_mw",          64'(b0.memory_writable), 64'd1);
    chk("rst_ld_valid",    64'(b0.ld_valid), 64'd0);
    chk("rst_st_ready",    64'(b0.st_ready), 64'd0);
    chk("rst_out_wen",     64'(b0.out_wen), 64'd0);
    chk("rst_output_rdy",  64'(b0.output_ready), 64'd0);
    chk("rst_addrr",       64'(b0.addrr), 64'd0);
    chk("rst_addrw",       64'(b0.addrw), 64'd0);
    chk("rst_dout_up",     64'(b0.data_out_up), 64'd0);
    chk("rst_ld_a_up",     64'(b0.ld_a_up), 64'd0);
    chk("rst_ld_idx",      64'(b0.ld_idx), 64'd0);
  endtask

  // One run on u0 with ld_ready=1 and a core answering 100+idx right after each load.
  // hold: keep start high throughout; extra: offer a 9th result after 8 accepted.
  task automatic run0(input bit hold, input bit extra);
    int q[$];
    int nexp = 0, wcnt = 0, acc = 0, orc = 0, first = -1, last = -1, done_rel = -1;
    @(negedge clk);
    b0.start = 1'b1;
    for (int rel = 1; rel <= 80; rel++) begin
      @(negedge clk);
      b0.start    = hold;
      b0.ld_ready = 1'b1;
      b0.st_valid = 1'b0;
      if (q.size() > 0) begin
        b0.st_valid = 1'b1;
        b0.st_up    = 32'(q[0]);
        b0.st_down  = 32'(q[0]) + 32'd100;
      end else if (extra && acc >= 8 && (done_rel < 0 || rel <= done_rel + 1)) begin
        b0.st_valid = 1'b1;
        b0.st_up    = 32'd999;
        b0.st_down  = 32'd999;
      end
      #1;
      if (rel == 1) begin
        chk("load_mw",    64'(b0.memory_writable), 64'd0);
        chk("load_sready", 64'(b0.start_ready), 64'd0);
      end
      if (rel <= 8) chk("addrr_seq", 64'(b0.addrr), 64'((rel-1)*4));
      if (b0.ld_valid && b0.ld_ready) begin
        chk("ld_idx",    64'(b0.ld_idx),    64'(nexp));
        chk("ld_a_up",   64'(b0.ld_a_up),   64'(nexp));
        chk("ld_a_down", 64'(b0.ld_a_down), 64'(nexp+8));
        chk("ld_b_up",   64'(b0.ld_b_up),   64'(nexp+16));
        chk("ld_b_down", 64'(b0.ld_b_down), 64'(nexp+24));
        if (first < 0) first = rel;
        last = rel;
        nexp++;
        q.push_back(100 + int'(b0.ld_idx));
      end
      if (acc >= 8 && b0.st_valid) chk("st_ninth_rdy", 64'(b0.st_ready), 64'd0);
      else if (b0.st_valid && b0.st_ready) begin
        acc++;
        void'(q.pop_front());
      end
      if (b0.out_wen != '0) begin
        chk("wr_addrw", 64'(b0.addrw),         64'(wcnt*4));
        chk("wr_up",    64'(b0.data_out_up),   64'(100+wcnt));
        chk("wr_down",  64'(b0.data_out_down), 64'(200+wcnt));
        chk("wr_wen",   64'(b0.out_wen),       64'hF);
        wcnt++;
      end
      if (b0.output_ready) begin
        orc++;
        done_rel = rel;
        chk("done_writes", 64'(wcnt), 64'd8);
        chk("done_loads",  64'(nexp), 64'd8);
        chk("done_mw",     64'(b0.memory_writable), 64'd1);
      end
      if (done_rel > 0 && rel == done_rel + 1) begin
        chk("idle_sready", 64'(b0.start_ready), 64'd1);
        chk("or_pulse",    64'(b0.output_ready), 64'd0);
        if (!hold) break;
      end
      if (hold && done_rel > 0 && rel == done_rel + 2) begin
        chk("restart_sready", 64'(b0.start_ready), 64'd0);
        chk("restart_mw",     64'(b0.memory_writable), 64'd0);
        chk("restart_addrr",  64'(b0.addrr), 64'd0);
        break;
      end
    end
    b0.st_valid = 1'b0;
    chk("first_vld_rel", 64'(first), 64'd3);
    chk("last_vld_rel",  64'(last),  64'd10);
    chk("loads_total",   64'(nexp),  64'd8);
    chk("writes_total",  64'(wcnt),  64'd8);
    chk("or_count",      64'(orc),   64'd1);
  endtask

  // One run on u1 (RD_LAT=3, word addresses, W=64) with ld_ready toggling.
  task automatic run1();
    longint q[$];
    int nexp = 0, wcnt = 0, orc = 0, done_rel = -1, maxocc = 0;
    @(negedge clk);
    b1.start = 1'b1;
    for (int rel = 1; rel <= 120; rel++) begin
      @(negedge clk);
      b1.start    = 1'b0;
      b1.ld_ready = ((rel % 2) == 1);
      b1.st_valid = (q.size() > 0);
      if (q.size() > 0) begin
        b1.st_up   = 64'(q[0]);
        b1.st_down = 64'(q[0]) + 64'd100;
      end
      #1;
      if (rel == 1) chk("w_addrr0", 64'(b1.addrr), 64'd0);
      if (rel == 2) chk("w_addrr1", 64'(b1.addrr), 64'd1);
      if (int'(u1.occ) > maxocc) maxocc = int'(u1.occ);
      if (nexp < 8) chk("w_mw_load", 64'(b1.memory_writable), 64'd0);
      if (b1.ld_valid && b1.ld_ready) begin
        chk("w_ld_idx",    64'(b1.ld_idx),    64'(nexp));
        chk("w_ld_a_up",   b1.ld_a_up,        64'(nexp));
        chk("w_ld_a_down", b1.ld_a_down,      64'(nexp+8));
        chk("w_ld_b_up",   b1.ld_b_up,        64'(nexp+16));
        chk("w_ld_b_down", b1.ld_b_down,      64'(nexp+24));
        nexp++;
        q.push_back(longint'(100 + int'(b1.ld_idx)));
      end
      if (b1.st_valid && b1.st_ready) void'(q.pop_front());
      if (b1.out_wen != '0) begin
        chk("w_addrw", 64'(b1.addrw),   64'(wcnt));
        chk("w_up",    b1.data_out_up,   64'(100+wcnt));
        chk("w_down",  b1.data_out_down, 64'(200+wcnt));
        chk("w_wen",   64'(b1.out_wen), 64'hFF);
        wcnt++;
      end
      if (b1.output_ready) begin
        orc++;
        done_rel = rel;
        chk("w_done_mw", 64'(b1.memory_writable), 64'd1);
      end
      if (done_rel > 0 && rel == done_rel + 1) begin
        chk("w_idle_sready", 64'(b1.start_ready), 64'd1);
        break;
      end
    end
    b1.st_valid = 1'b0;
    chk("w_occ_le5",  64'(maxocc <= 5), 64'd1);
    chk("w_loads",    64'(nexp), 64'd8);
    chk("w_writes",   64'(wcnt), 64'd8);
    chk("w_or_count", 64'(orc),  64'd1);
  endtask

  initial begin
    bit found;
    b0.start = 1'b0; b0.ld_ready = 1'b0; b0.st_valid = 1'b0; b0.st_up = '0; b0.st_down = '0;
    b1.start = 1'b0; b1.ld_ready = 1'b0; b1.st_valid = 1'b0; b1.st_up = '0; b1.st_down = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_rst0();
    chk("w_rst_sready", 64'(b1.start_ready), 64'd1);
    chk("w_rst_ldv",    64'(b1.ld_valid), 64'd0);
    chk("w_rst_wen",    64'(b1.out_wen), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("idle_sready0", 64'(b0.start_ready), 64'd1);

    run0(1'b0, 1'b0);
    run1();
    run0(1'b1, 1'b1);

    // new run is in LOAD: reset while i=5
    b0.start    = 1'b0;
    b0.st_valid = 1'b0;
    b0.ld_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (b0.addrr == 5'd20) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_i5_seen", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_rst0();
    @(negedge clk);
    rst_n = 1'b1;
    run0(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
